// File: rtl/conv_out_pool.sv
// Post-conv output stage: drops incomplete-window edge samples, applies ReLU and
// shift requantisation with saturation, then 2x2 stride-2 max-pools the result.
module conv_out_pool #(
    parameter int DATA_WIDTH  = 16,
    parameter int OUT_WIDTH   = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int IFM_W       = 10,
    parameter int IFM_H       = 10,
    parameter int SHIFT       = 0
) (
    input  logic                         clk1,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    output logic                         out_valid,
    output logic        [OUT_WIDTH-1:0]  out_data,
    output logic                         out_last,
    output logic                         sat
);

    localparam int OFM_W = IFM_W - KERNEL_SIZE + 1;
    localparam int OFM_H = IFM_H - KERNEL_SIZE + 1;
    localparam int PW    = OFM_W / 2;
    localparam int PH    = OFM_H / 2;
    localparam int CW    = (IFM_W > 1) ? $clog2(IFM_W) : 1;
    localparam int RW    = (IFM_H > 1) ? $clog2(IFM_H) : 1;
    localparam int IW    = (PW > 1) ? $clog2(PW) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IFM_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IFM_H - 1);
    localparam logic [CW-1:0] KM1_C    = CW'(KERNEL_SIZE - 1);
    localparam logic [RW-1:0] KM1_R    = RW'(KERNEL_SIZE - 1);
    localparam logic [CW-1:0] CC_LIM   = CW'(2 * PW);
    localparam logic [RW-1:0] CR_LIM   = RW'(2 * PH);
    localparam logic [CW-1:0] CC_END   = CW'(2 * PW - 1);
    localparam logic [RW-1:0] CR_END   = RW'(2 * PH - 1);

    localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = DATA_WIDTH'((1 << OUT_WIDTH) - 1);

    // ReLU + arithmetic shift + clip; MSB of the result flags a clip.
    function automatic logic [OUT_WIDTH:0] requant(input logic signed [DATA_WIDTH-1:0] d);
        logic signed [DATA_WIDTH-1:0] s;
        s = d >>> SHIFT;
        if (d < 0)
            return '0;
        else if (s > SAT_MAX)
            return {1'b1, {OUT_WIDTH{1'b1}}};
        else
            return {1'b0, OUT_WIDTH'(s)};
    endfunction

    function automatic logic [OUT_WIDTH-1:0] umax(input logic [OUT_WIDTH-1:0] a,
                                                   input logic [OUT_WIDTH-1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // ---- stage p0: position tracking and keep decision (combinational) ----
    logic [CW-1:0]      cc_p0;
    logic [RW-1:0]      cr_p0;
    logic               keep_p0;
    logic               last_p0;
    logic [IW-1:0]      idx_p0;
    logic [OUT_WIDTH:0] rq_p0;

    assign cc_p0   = col - KM1_C;
    assign cr_p0   = row - KM1_R;
    assign keep_p0 = in_valid && (col >= KM1_C) && (row >= KM1_R)
                     && (cc_p0 < CC_LIM) && (cr_p0 < CR_LIM);
    assign last_p0 = (cc_p0 == CC_END) && (cr_p0 == CR_END);
    assign idx_p0  = IW'(cc_p0 >> 1);
    assign rq_p0   = requant(data_in);

    always_ff @(posedge clk1) begin
        if (rst || clr) begin
            col <= '0;
            row <= '0;
        end else if (in_valid) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // ---- stage p1: requantised sample register ----
    logic                 vld_p1;
    logic [OUT_WIDTH-1:0] q_p1;
    logic                 cc_odd_p1;
    logic                 cr_odd_p1;
    logic [IW-1:0]        idx_p1;
    logic                 last_p1;

    always_ff @(posedge clk1) begin
        if (rst || clr) begin
            vld_p1 <= 1'b0;
            sat    <= 1'b0;
        end else begin
            vld_p1 <= keep_p0;
            sat    <= keep_p0 && rq_p0[OUT_WIDTH];
        end
    end

    always_ff @(posedge clk1) begin
        if (keep_p0) begin
            q_p1      <= rq_p0[OUT_WIDTH-1:0];
            cc_odd_p1 <= cc_p0[0];
            cr_odd_p1 <= cr_p0[0];
            idx_p1    <= idx_p0;
            last_p1   <= last_p0;
        end
    end

    // ---- stage p2: horizontal max, half-row buffer, vertical max ----
    logic [OUT_WIDTH-1:0] hreg;
    logic [OUT_WIDTH-1:0] pool_buf [PW];
    logic [OUT_WIDTH-1:0] h_p1;
    logic                 live_p1;
    logic                 emit_p1;

    assign live_p1 = vld_p1 && !rst && !clr;
    assign h_p1    = umax(hreg, q_p1);
    assign emit_p1 = live_p1 && cc_odd_p1 && cr_odd_p1;

    always_ff @(posedge clk1) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= emit_p1;
            out_last  <= emit_p1 && last_p1;
            if (emit_p1)
                out_data <= umax(pool_buf[idx_p1], h_p1);
        end
    end

    always_ff @(posedge clk1) begin
        if (live_p1) begin
            if (!cc_odd_p1)
                hreg <= q_p1;
            else if (!cr_odd_p1)
                pool_buf[idx_p1] <= h_p1;
        end
    end

endmodule

// File: tb/tb_conv_out_pool.sv
// Directed bench for conv_out_pool: table-driven full frames plus reset and clr sequences.
module tb_conv_out_pool;

    logic              clk1 = 1'b0;
    logic              rst, clr, in_valid;
    logic signed [15:0] data_in;
    logic              out_valid_a, out_last_a, sat_a;
    logic [7:0]        out_data_a;
    logic              out_valid_b, out_last_b, sat_b;
    logic [7:0]        out_data_b;

    always #5 clk1 = ~clk1;

    conv_out_pool #(.SHIFT(0)) dut_a (
        .clk1(clk1), .rst(rst), .clr(clr), .in_valid(in_valid), .data_in(data_in),
        .out_valid(out_valid_a), .out_data(out_data_a), .out_last(out_last_a), .sat(sat_a)
    );

    conv_out_pool #(.SHIFT(2)) dut_b (
        .clk1(clk1), .rst(rst), .clr(clr), .in_valid(in_valid), .data_in(data_in),
        .out_valid(out_valid_b), .out_data(out_data_b), .out_last(out_last_b), .sat(sat_b)
    );

    int cyc = 0;
    always @(posedge clk1) cyc <= cyc + 1;

    int vals_a[$];
    int lasts_a[$];
    int ocyc_a[$];
    int vals_b[$];
    int lasts_b[$];
    int sat_cnt_a = 0;
    int sat_cnt_b = 0;

    always @(negedge clk1) begin
        if (out_valid_a) begin
            vals_a.push_back(int'(out_data_a));
            lasts_a.push_back(int'(out_last_a));
            ocyc_a.push_back(cyc);
        end
        if (out_valid_b) begin
            vals_b.push_back(int'(out_data_b));
            lasts_b.push_back(int'(out_last_b));
        end
        if (sat_a) sat_cnt_a++;
        if (sat_b) sat_cnt_b++;
    end

    int errors = 0;
    int checks = 0;
    int samp_cyc[100];
    int ramp_exp[16] = '{51, 53, 55, 57, 83, 85, 87, 89,
                         115, 117, 119, 121, 147, 149, 151, 153};

    typedef struct {
        string       name;
        bit          ramp;
        logic [15:0] cval;
        bit          gaps;
        bit          use_b;
        int          expv;      // -1 selects the ramp table
        int          exp_sat;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic send_frame(input int n, input bit ramp, input logic [15:0] cv, input bit gaps);
        for (int i = 0; i < n; i++) begin
            @(posedge clk1);
            #1;
            in_valid = 1'b1;
            data_in  = ramp ? 16'((i / 10) * 16 + (i % 10)) : cv;
            if (i < 100) samp_cyc[i] = cyc + 1;
            if (gaps) begin
                @(posedge clk1);
                #1;
                in_valid = 1'b0;
            end
        end
        @(posedge clk1);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (3) @(posedge clk1);
        @(negedge clk1);
    endtask

    task automatic check_frame(input string tag, input bit use_b, input int base,
                               input int expv, input bit lat);
        int sz;
        int idx;
        sz = use_b ? vals_b.size() : vals_a.size();
        chk($sformatf("%s_count", tag), sz - base, 16);
        for (int k = 0; k < 16; k++) begin
            if (base + k < sz) begin
                chk($sformatf("%s_val%0d", tag, k),
                    use_b ? vals_b[base + k] : vals_a[base + k],
                    (expv < 0) ? ramp_exp[k] : expv);
                chk($sformatf("%s_last%0d", tag, k),
                    use_b ? lasts_b[base + k] : lasts_a[base + k], (k == 15) ? 1 : 0);
                if (lat && !use_b) begin
                    idx = (2 * (k / 4) + 3) * 10 + 2 * (k % 4) + 3;
                    chk($sformatf("%s_lat%0d", tag, k), ocyc_a[base + k], samp_cyc[idx] + 1);
                end
            end else begin
                chk($sformatf("%s_missing%0d", tag, k), -1, (expv < 0) ? ramp_exp[k] : expv);
            end
        end
    endtask

    task automatic check_idle(input string tag);
        chk($sformatf("%s_out_valid", tag), int'(out_valid_a), 0);
        chk($sformatf("%s_out_data", tag),  int'(out_data_a), 0);
        chk($sformatf("%s_out_last", tag),  int'(out_last_a), 0);
        chk($sformatf("%s_sat", tag),       int'(sat_a), 0);
        chk($sformatf("%s_b_out_valid", tag), int'(out_valid_b), 0);
        chk($sformatf("%s_b_out_data", tag),  int'(out_data_b), 0);
    endtask

    initial begin
        int base;
        int sbase;

        rst      = 1'b1;
        clr      = 1'b0;
        in_valid = 1'b0;
        data_in  = '0;
        repeat (3) @(posedge clk1);
        @(negedge clk1);
        check_idle("reset");
        @(posedge clk1);
        #1;
        rst = 1'b0;

        vecs[0] = '{"ramp",       1'b1, 16'h0000, 1'b0, 1'b0, -1,  0};
        vecs[1] = '{"ramp_gaps",  1'b1, 16'h0000, 1'b1, 1'b0, -1,  0};
        vecs[2] = '{"negative",   1'b0, 16'hFFFB, 1'b0, 1'b0, 0,   0};
        vecs[3] = '{"sat_shift0", 1'b0, 16'h0300, 1'b0, 1'b0, 255, 64};
        vecs[4] = '{"shift2",     1'b0, 16'h0300, 1'b0, 1'b1, 192, 0};

        for (int v = 0; v < 5; v++) begin
            base  = vecs[v].use_b ? vals_b.size() : vals_a.size();
            sbase = vecs[v].use_b ? sat_cnt_b : sat_cnt_a;
            send_frame(100, vecs[v].ramp, vecs[v].cval, vecs[v].gaps);
            drain();
            check_frame(vecs[v].name, vecs[v].use_b, base, vecs[v].expv, vecs[v].ramp);
            chk($sformatf("%s_sat_count", vecs[v].name),
                (vecs[v].use_b ? sat_cnt_b : sat_cnt_a) - sbase, vecs[v].exp_sat);
        end

        // Reset right after sample 39: outputs for 33,35,37 only; 39 is in flight and dropped.
        base = vals_a.size();
        send_frame(40, 1'b1, 16'h0000, 1'b0);
        rst = 1'b1;
        repeat (3) @(posedge clk1);
        @(negedge clk1);
        check_idle("mid_reset");
        @(posedge clk1);
        #1;
        rst = 1'b0;
        drain();
        chk("rst_partial_count", vals_a.size() - base, 3);
        if (vals_a.size() > base) chk("rst_partial_first", vals_a[base], 51);
        base = vals_a.size();
        send_frame(100, 1'b1, 16'h0000, 1'b0);
        drain();
        check_frame("after_rst", 1'b0, base, -1, 1'b1);

        // clr arrives with sample 50; that sample is dropped and the frame restarts.
        base = vals_a.size();
        send_frame(50, 1'b1, 16'h0000, 1'b0);
        clr      = 1'b1;
        in_valid = 1'b1;
        data_in  = 16'sh7FFF;
        @(posedge clk1);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        drain();
        chk("clr_partial_count", vals_a.size() - base, 4);
        base = vals_a.size();
        send_frame(100, 1'b1, 16'h0000, 1'b0);
        drain();
        check_frame("after_clr", 1'b0, base, -1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
